// File: rtl/wave_gen_pkg.sv
// Shared encodings for the multi_wave_gen tone generator: waveform/step-mode enums,
// button and LED bit positions.
package wave_gen_pkg;

  typedef enum logic [1:0] {
    WAVE_SQ  = 2'b00,
    WAVE_TRI = 2'b01,
    WAVE_SAW = 2'b10
  } wave_t;

  typedef enum logic {
    STEP_LIN = 1'b0,
    STEP_EXP = 1'b1
  } step_t;

  localparam int BTN_UP   = 0;
  localparam int BTN_DN   = 1;
  localparam int BTN_MODE = 2;
  localparam int BTN_WAVE = 3;

  localparam int LED_STEP    = 0;
  localparam int LED_WAVE_LO = 1;
  localparam int LED_WAVE_HI = 2;
  localparam int LED_LIMIT   = 3;

endpackage

// File: rtl/wave_gen_ctrl.sv
// Button decode, step-mode/waveform registers and saturating FCW update (WAVE_SHAPES_EN adds tri/saw).
// Settings and leds change one cycle after a button pulse; no backpressure, buttons are always accepted.
module wave_gen_ctrl
  import wave_gen_pkg::*;
#(
  parameter int          PHASE_WIDTH = 24,
  parameter int unsigned FCW_DEFAULT = 60507,
  parameter int unsigned FCW_STEP    = 1024,
  parameter int unsigned FCW_MIN     = 1,
  parameter int unsigned FCW_MAX     = 8388608
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3:0]             buttons,
  output logic [PHASE_WIDTH-1:0] fcw,
  output logic [1:0]             wave,
  output logic [3:0]             leds
);

  localparam int XW = PHASE_WIDTH + 1;
  localparam logic [XW-1:0]          STEP_X = XW'(FCW_STEP);
  localparam logic [XW-1:0]          MIN_X  = XW'(FCW_MIN);
  localparam logic [XW-1:0]          MAX_X  = XW'(FCW_MAX);
  localparam logic [PHASE_WIDTH-1:0] MIN_P  = PHASE_WIDTH'(FCW_MIN);
  localparam logic [PHASE_WIDTH-1:0] MAX_P  = PHASE_WIDTH'(FCW_MAX);
  localparam logic [PHASE_WIDTH-1:0] DEF_P  = PHASE_WIDTH'(FCW_DEFAULT);

  logic [PHASE_WIDTH-1:0] fcw_q, fcw_d;
  step_t                  step_q, step_d;
  logic [XW-1:0]          fcw_x, up_x, dn_x;

  logic up_only, dn_only;
  assign up_only = buttons[BTN_UP] && !buttons[BTN_DN];
  assign dn_only = buttons[BTN_DN] && !buttons[BTN_UP];

  // One extra bit of headroom: a set MSB after subtraction is the lin-mode underflow.
  always_comb begin
    fcw_d  = fcw_q;
    step_d = step_q;
    fcw_x  = {1'b0, fcw_q};
    up_x   = (step_q == STEP_EXP) ? (fcw_x << 1) : (fcw_x + STEP_X);
    dn_x   = (step_q == STEP_EXP) ? (fcw_x >> 1) : (fcw_x - STEP_X);
    if (up_only) begin
      fcw_d = (up_x > MAX_X) ? MAX_P : up_x[PHASE_WIDTH-1:0];
    end else if (dn_only) begin
      fcw_d = (dn_x[XW-1] || (dn_x < MIN_X)) ? MIN_P : dn_x[PHASE_WIDTH-1:0];
    end
    if (buttons[BTN_MODE]) begin
      step_d = (step_q == STEP_LIN) ? STEP_EXP : STEP_LIN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fcw_q  <= DEF_P;
      step_q <= STEP_LIN;
    end else begin
      fcw_q  <= fcw_d;
      step_q <= step_d;
    end
  end

`ifdef WAVE_SHAPES_EN
  wave_t wave_q, wave_d;

  always_comb begin
    wave_d = wave_q;
    if (buttons[BTN_WAVE]) begin
      case (wave_q)
        WAVE_SQ:  wave_d = WAVE_TRI;
        WAVE_TRI: wave_d = WAVE_SAW;
        default:  wave_d = WAVE_SQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) wave_q <= WAVE_SQ;
    else        wave_q <= wave_d;
  end

  assign wave = wave_q;
`else
  logic unused_wave_btn;
  assign unused_wave_btn = buttons[BTN_WAVE];
  assign wave = WAVE_SQ;
`endif

  assign fcw = fcw_q;

  always_comb begin
    leds                          = '0;
    leds[LED_STEP]                = (step_q == STEP_EXP);
    leds[LED_WAVE_HI:LED_WAVE_LO] = wave;
    leds[LED_LIMIT]               = (fcw_q == MIN_P) || (fcw_q == MAX_P);
  end

endmodule

// File: rtl/multi_wave_gen.sv
// NCO tone generator top: phase accumulator plus registered shape code (WAVE_SHAPES_EN adds tri/saw).
// code updates one cycle after a next_sample pull and holds otherwise; no backpressure.
module multi_wave_gen
  import wave_gen_pkg::*;
#(
  parameter int          CODE_WIDTH  = 10,
  parameter int          PHASE_WIDTH = 24,
  parameter int unsigned FCW_DEFAULT = 60507,
  parameter int unsigned FCW_STEP    = 1024,
  parameter int unsigned FCW_MIN     = 1,
  parameter int unsigned FCW_MAX     = 8388608
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  next_sample,
  input  logic [3:0]            buttons,
  output logic [CODE_WIDTH-1:0] code,
  output logic [3:0]            leds
);

  logic [PHASE_WIDTH-1:0] phase, phase_nxt, fcw;
  logic [1:0]             wave;

  wave_gen_ctrl #(
    .PHASE_WIDTH (PHASE_WIDTH),
    .FCW_DEFAULT (FCW_DEFAULT),
    .FCW_STEP    (FCW_STEP),
    .FCW_MIN     (FCW_MIN),
    .FCW_MAX     (FCW_MAX)
  ) u_ctrl (
    .clk     (clk),
    .rst_n   (rst_n),
    .buttons (buttons),
    .fcw     (fcw),
    .wave    (wave),
    .leds    (leds)
  );

  function automatic logic [CODE_WIDTH-1:0] shape(input logic [PHASE_WIDTH-1:0] ph,
                                                  input logic [1:0]             wv);
    logic [CODE_WIDTH-1:0] r;
    case (wv)
      WAVE_TRI: r = ph[PHASE_WIDTH-1] ? ~ph[PHASE_WIDTH-2 -: CODE_WIDTH]
                                      :  ph[PHASE_WIDTH-2 -: CODE_WIDTH];
      WAVE_SAW: r = ph[PHASE_WIDTH-1 -: CODE_WIDTH];
      default:  r = ph[PHASE_WIDTH-1] ? '0 : '1;
    endcase
    return r;
  endfunction

  // Code is shaped from the post-add phase so it lands on the same edge as the accumulator.
  assign phase_nxt = phase + fcw;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase <= '0;
      code  <= '0;
    end else if (next_sample) begin
      phase <= phase_nxt;
      code  <= shape(phase_nxt, wave);
    end
  end

endmodule

// File: tb/tb_multi_wave_gen.sv
// Scoreboarded bench for multi_wave_gen: pulls push expected codes, a monitor pops and compares.
module tb_multi_wave_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       next_sample = 1'b0;
  logic [3:0] buttons = 4'b0000;
  logic [9:0] code;
  logic [3:0] leds;

  multi_wave_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .next_sample (next_sample),
    .buttons     (buttons),
    .code        (code),
    .leds        (leds)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int unsigned exp_q[$];
  longint      m_phase, m_fcw;
  int          m_wave;
  bit          m_step;
  logic        pull_seen = 1'b0;

  longint up_tbl[8]  = '{121014, 242028, 484056, 968112, 1936224, 3872448, 7744896, 8388608};
  longint dn_tbl[16] = '{30253, 15126, 7563, 3781, 1890, 945, 472, 236,
                         118, 59, 29, 14, 7, 3, 1, 1};

  task automatic chk(input string name, input longint act, input longint want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  function automatic int shape_m(input longint ph, input int wv);
    int t;
    if (wv == 2) return int'(ph / 16384);
    if (wv == 1) begin
      t = int'((ph / 8192) % 1024);
      return (ph >= 8388608) ? 1023 - t : t;
    end
    return (ph >= 8388608) ? 0 : 1023;
  endfunction

  // Monitor: a pull seen at an edge means a fresh code is due by the next falling edge.
  always @(posedge clk) pull_seen <= rst_n && next_sample;

  always @(negedge clk) begin
    if (pull_seen) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL code_unexpected got=%0d want=none", code);
      end else begin
        int unsigned e;
        e = exp_q.pop_front();
        if (code !== e[9:0]) begin
          failures++;
          $display("FAIL code_sample got=%0d want=%0d", code, e);
        end
      end
    end
  end

  task automatic model_reset();
    m_phase = 0;
    m_fcw   = 60507;
    m_wave  = 0;
    m_step  = 1'b0;
  endtask

  task automatic cycle(input bit ns, input logic [3:0] b);
    next_sample = ns;
    buttons     = b;
    if (ns) begin
      m_phase = (m_phase + m_fcw) % 16777216;
      exp_q.push_back(shape_m(m_phase, m_wave));
    end
    if (b[0] && !b[1]) begin
      m_fcw = m_step ? m_fcw * 2 : m_fcw + 1024;
      if (m_fcw > 8388608) m_fcw = 8388608;
    end else if (b[1] && !b[0]) begin
      m_fcw = m_step ? m_fcw / 2 : m_fcw - 1024;
      if (m_fcw < 1) m_fcw = 1;
    end
    if (b[2]) m_step = !m_step;
`ifdef WAVE_SHAPES_EN
    if (b[3]) m_wave = (m_wave + 1) % 3;
`endif
    @(posedge clk);
    #1;
    next_sample = 1'b0;
    buttons     = 4'b0000;
  endtask

  // Reset asserted with every other input active to show it wins.
  task automatic do_reset();
    rst_n       = 1'b0;
    next_sample = 1'b1;
    buttons     = 4'b1111;
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    next_sample = 1'b0;
    buttons     = 4'b0000;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    chk("rst_code", code, 0);
    chk("rst_leds", leds, 0);
    chk("rst_fcw", dut.fcw, 60507);
    chk("rst_phase", dut.phase, 0);

    cycle(1, 4'b0000);
    chk("first_phase", dut.phase, 60507);
    chk("first_code_sq", code, 1023);

`ifdef WAVE_SHAPES_EN
    do_reset();
    cycle(0, 4'b1000);
    chk("leds_tri", leds, 4'b0010);
    cycle(0, 4'b1000);
    chk("leds_saw", leds, 4'b0100);
    cycle(1, 4'b0000);
    chk("first_code_saw", code, 3);
    cycle(0, 4'b1000);
    chk("leds_sq_wrap", leds, 4'b0000);
    do_reset();
    cycle(0, 4'b1000);
    cycle(1, 4'b0000);
    chk("first_code_tri", code, 7);
`else
    cycle(0, 4'b1000);
    chk("leds_wave_tied", leds, 4'b0000);
    cycle(1, 4'b0000);
`endif

    // Linear stepping
    do_reset();
    cycle(0, 4'b0001);
    chk("lin_up", dut.fcw, 61531);
    cycle(0, 4'b0010);
    cycle(0, 4'b0010);
    chk("lin_dn2", dut.fcw, 59483);
    cycle(0, 4'b0011);
    chk("lin_both", dut.fcw, 59483);
    cycle(1, 4'b0001);
    chk("press_pull_phase", dut.phase, 59483);
    chk("press_pull_fcw", dut.fcw, 60507);

    // Exponential up to the Nyquist clamp
    do_reset();
    cycle(0, 4'b0100);
    chk("leds_exp", leds, 4'b0001);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 4'b0001);
      chk($sformatf("exp_up_%0d", i), dut.fcw, up_tbl[i]);
    end
    chk("leds_max", leds, 4'b1001);
    cycle(0, 4'b0001);
    chk("exp_up_hold", dut.fcw, 8388608);

    // Exponential down to the floor, then linear underflow
    do_reset();
    cycle(0, 4'b0100);
    for (int i = 0; i < 16; i++) begin
      cycle(0, 4'b0010);
      chk($sformatf("exp_dn_%0d", i), dut.fcw, dn_tbl[i]);
    end
    chk("leds_min", leds, 4'b1001);
    cycle(0, 4'b0100);
    cycle(0, 4'b0010);
    chk("lin_dn_at_min", dut.fcw, 1);
    chk("leds_min_lin", leds, 4'b1000);
    cycle(0, 4'b0001);
    chk("lin_up_from_min", dut.fcw, 1025);
    chk("leds_off_limit", leds, 4'b0000);
    cycle(0, 4'b0010);
    chk("lin_underflow", dut.fcw, 1);

    // Long runs checked by the scoreboard
    do_reset();
    cycle(0, 4'b0100);
    for (int i = 0; i < 3; i++) cycle(0, 4'b0001);
    cycle(0, 4'b1000);
    for (int i = 0; i < 1000; i++) cycle(1, 4'b0000);
    cycle(1, 4'b1000);
    cycle(1, 4'b0010);
    for (int i = 0; i < 300; i++) cycle(1, 4'b0000);
    cycle(0, 4'b0000);

    do_reset();
    chk("midrst_code", code, 0);
    chk("midrst_leds", leds, 0);
    chk("midrst_fcw", dut.fcw, 60507);
    chk("midrst_phase", dut.phase, 0);
    cycle(1, 4'b0000);
    chk("midrst_first_code", code, 1023);

    cycle(0, 4'b0000);
    cycle(0, 4'b0000);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_wave_gen.md
Name: multi_wave_gen

Overview:
Parametrised successor to the lab square-wave source: a phase-accumulator (NCO) tone generator for the audio DAC path. Produces square, triangle or sawtooth codes. Pitch is set by a frequency control word (FCW) adjusted from debounced buttons in linear or exponential step mode. The DAC-side consumer pulls one code per next_sample pulse.

Parameters:
CODE_WIDTH, 10, width of DAC code output
PHASE_WIDTH, 24, phase accumulator / FCW width; must be >= CODE_WIDTH+2
FCW_DEFAULT, 60507, reset FCW (~440 Hz at 122 kHz sample pull rate)
FCW_STEP, 1024, linear-mode FCW increment/decrement
FCW_MIN, 1, lower FCW saturation limit
FCW_MAX, 8388608, upper FCW saturation limit (2^(PHASE_WIDTH-1), Nyquist)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
next_sample  in  1  one-cycle pull strobe from DAC side
buttons  in  4  single-cycle pulses, already synchronised/debounced/edge-detected; [0] freq up, [1] freq down, [2] toggle step mode, [3] cycle waveform
code  out  CODE_WIDTH  current sample code, registered
leds  out  4  [0] step mode (0 lin, 1 exp); [2:1] waveform (00 square, 01 triangle, 10 sawtooth); [3] FCW at FCW_MIN or FCW_MAX

Behaviour:
- Reset (rst_n low at a rising edge): phase=0, fcw=FCW_DEFAULT, step mode=lin, waveform=square, code=0, leds=4'b0000 (leds[3]=1 only if FCW_DEFAULT equals a limit).
- Reset overrides all other inputs in that cycle. Mid-operation reset discards phase; the first sample after reset starts from phase 0.
- Sample path: on an edge with next_sample=1, phase <= phase+fcw (mod 2^PHASE_WIDTH wrap, no saturation), and code <= shape(phase+fcw) in the same edge. Latency one cycle; code holds between pulses.
- shape, P=PHASE_WIDTH, W=CODE_WIDTH:
  - square: phase[P-1]==0 -> 2^W-1, else 0.
  - sawtooth: phase[P-1 -: W].
  - triangle: phase[P-1]==0 -> phase[P-2 -: W], else bitwise-inverted phase[P-2 -: W].
- Control FSM (step-mode register plus 3-state waveform register SQ->TRI->SAW->SQ), evaluated on every edge:
  - buttons[0] only, lin: fcw = min(fcw+FCW_STEP, FCW_MAX).
  - buttons[0] only, exp: fcw = min(fcw<<1, FCW_MAX).
  - buttons[1] only, lin: fcw = max(fcw-FCW_STEP, FCW_MIN). Underflow must be detected, with no wrap.
  - buttons[1] only, exp: fcw = max(fcw>>1, FCW_MIN).
  - buttons[0] and [1] together: fcw unchanged.
  - buttons[2]: toggle step mode. buttons[3]: advance waveform. Both are independent of [0]/[1] and may coincide with them.
  - FCW arithmetic is done at PHASE_WIDTH+1 bits before the clamp.
- Simultaneous next_sample and a button: the sample uses the old fcw/waveform; the new settings apply from the next pulse.
- leds mirror the registered state, so they update one cycle after the button pulse.
- Waveform change does not reset phase. The output changes shape at the next sample, with no glitch between samples.

Optional Feature:
WAVE_SHAPES_EN:
- Defined: triangle and sawtooth are available, and buttons[3] cycles the waveform as above.
- Undefined: square only. The waveform register is removed, buttons[3] is ignored, and leds[2:1] is tied to 2'b00.
- FCW, step mode and leds[0]/[3] behave identically in both builds.

Decomposition:
- Package wave_gen_pkg holds:
  - waveform encoding constants WAVE_SQ=2'b00, WAVE_TRI=2'b01, WAVE_SAW=2'b10;
  - step-mode constants STEP_LIN=1'b0, STEP_EXP=1'b1;
  - LED bit-index constants.
- One sub-module, wave_gen_ctrl: button decode, step-mode/waveform registers, saturating FCW update and leds.
- The top keeps the phase accumulator and shape/code register.

Test Plan:
- Reset, then one next_sample pulse -> phase=60507; code=1023 (square). Same with saw selected -> code=3; triangle -> code=7. leds=0000 after reset.
- Lin mode: buttons[0] pulse -> fcw=61531. buttons[1] twice -> fcw=59483. buttons[0]+[1] together -> fcw unchanged. Sample taken in the same cycle as the press uses the old fcw.
- buttons[2] pulse -> leds[0]=1 next cycle. buttons[0] x8 -> fcw 121014, 242028, ..., 7744896, then 8388608 (clamped), leds[3]=1. Further up presses hold 8388608.
- Exp down from default x16 -> fcw halves and clamps at FCW_MIN=1, leds[3]=1. Lin down at 1 -> stays 1 with no wrap.
- buttons[3] x3 -> leds[2:1] 01, 10, 00. Triangle over 1000 pulls: code never exceeds 1023 and peaks when phase[23:22]=01->10. Without WAVE_SHAPES_EN, leds[2:1] stays 00.
- rst_n low one cycle after 300 samples with exp/saw/modified fcw -> next cycle code=0, leds=0000, fcw=60507. Next pull gives code=1023.
